// File: rtl/serial_pattern_gen_pkg.sv
// Shared definitions for the serial pattern generator and the detector bench:
// FSM encoding, LFSR constants, default geometry and a width helper.
package serial_pattern_gen_pkg;

  localparam int DEF_PAT_W = 3;
  localparam int DEF_CNT_W = 4;
  localparam int DEF_GAP   = 2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_FIN
  } state_e;

  function automatic int width_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_pattern_gen_if.sv
// Request/stream bundle between a burst requester (master) and the
// serial pattern generator (slave).
interface serial_pattern_gen_if
  import serial_pattern_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W
);

  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] repeat_cnt;
  logic             w;
  logic             w_valid;
  logic             busy;
  logic             done;

  modport master (
    output start, pattern, repeat_cnt,
    input  w, w_valid, busy, done
  );

  modport slave (
    input  start, pattern, repeat_cnt,
    output w, w_valid, busy, done
  );

endinterface

// File: rtl/serial_pattern_gen_lfsr8.sv
// 8-bit Fibonacci LFSR with enable; supplies noise on w during gap cycles
// when SERIAL_PATTERN_GEN_LFSR_FILL_EN is defined.
module lfsr8
  import serial_pattern_gen_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  output logic [7:0] q
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q <= LFSR_SEED;
    end else if (en) begin
      q <= {q[6:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/serial_pattern_gen.sv
// Serializes a latched pattern MSB first, repeat_cnt passes separated by GAP idle
// cycles. Optional macro SERIAL_PATTERN_GEN_LFSR_FILL_EN fills gaps with LFSR noise.
module serial_pattern_gen
  import serial_pattern_gen_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int CNT_W = DEF_CNT_W,
  parameter int GAP   = DEF_GAP
) (
  input  logic                  clk,
  input  logic                  resetn,
  serial_pattern_gen_if.slave   bus
);

  localparam int IDX_W = width_for(PAT_W);
  localparam int GAP_W = width_for(GAP + 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAT_W - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [PAT_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             fill_bit;
  logic             lfsr_en;

  assign lfsr_en = (state_d == ST_GAP);

`ifdef SERIAL_PATTERN_GEN_LFSR_FILL_EN
  logic [7:0] lfsr_q;

  lfsr8 u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .en     (lfsr_en),
    .q      (lfsr_q)
  );

  assign fill_bit = lfsr_q[7];
`else
  assign fill_bit = 1'b0;
`endif

  // NOTE: every signal gets a default at the top of the block so no path
  // through the case statement leaves a value unassigned (no latches).
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    gap_d   = gap_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pat_d = bus.pattern;
          rem_d = bus.repeat_cnt;
          if (bus.repeat_cnt != '0) begin
            state_d = ST_SEND;
            shreg_d = bus.pattern;
            idx_d   = IDX_LAST;
          end else begin
            state_d = ST_FIN;
          end
        end
      end

      ST_SEND: begin
        if (idx_q == '0) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = ST_FIN;
          end else if (GAP > 0) begin
            state_d = ST_GAP;
            gap_d   = GAP_W'(GAP - 1);
          end else begin
            // Back-to-back pass: reload without a bubble.
            shreg_d = pat_q;
            idx_d   = IDX_LAST;
          end
        end else begin
          shreg_d = shreg_q << 1;
          idx_d   = idx_q - IDX_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = ST_SEND;
          shreg_d = pat_q;
          idx_d   = IDX_LAST;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state so each one leaves a flop.
  always_comb begin
    w_valid_d = (state_d == ST_SEND);
    busy_d    = (state_d == ST_SEND) || (state_d == ST_GAP);
    done_d    = (state_d == ST_FIN);
    w_d       = 1'b0;
    if (state_d == ST_SEND) begin
      w_d = shreg_d[PAT_W-1];
    end else if (state_d == ST_GAP) begin
      w_d = fill_bit;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      idx_q     <= '0;
      rem_q     <= '0;
      gap_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      idx_q     <= idx_d;
      rem_q     <= rem_d;
      gap_q     <= gap_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.w       = w_q;
  assign bus.w_valid = w_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_serial_pattern_gen.sv
// Bench for serial_pattern_gen: two instances (GAP=2 and GAP=0) share one
// stimulus stream; a burst-position model predicts every output cycle.
module tb_serial_pattern_gen;

  localparam int P = 3;
  localparam int C = 4;
  localparam int GAP_A = 2;
  localparam int GAP_B = 0;

  logic         clk;
  logic         resetn;
  logic         start;
  logic [P-1:0] pattern;
  logic [C-1:0] rep;

  int n_checks = 0;
  int n_passed = 0;

  serial_pattern_gen_if #(.PAT_W(P), .CNT_W(C)) bus_a ();
  serial_pattern_gen_if #(.PAT_W(P), .CNT_W(C)) bus_b ();

  assign bus_a.start      = start;
  assign bus_a.pattern    = pattern;
  assign bus_a.repeat_cnt = rep;
  assign bus_b.start      = start;
  assign bus_b.pattern    = pattern;
  assign bus_b.repeat_cnt = rep;

  serial_pattern_gen #(.PAT_W(P), .CNT_W(C), .GAP(GAP_A)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_a)
  );

  serial_pattern_gen #(.PAT_W(P), .CNT_W(C), .GAP(GAP_B)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      n_passed++;
    end
  endtask

  // Model: each instance tracks its position t inside a burst (0 = idle).
  // Burst of length rep*P + (rep-1)*gap + 1; last position is the done cycle.
  int         t_m   [2];
  int         len_m [2];
  int         gap_m [2];
  logic [P-1:0] pat_m [2];
  logic [7:0] lfsr_m[2];
  logic [3:0] exp_m [2];   // {w, w_valid, busy, done}

  task automatic model_step();
    for (int d = 0; d < 2; d++) begin
      if (!resetn) begin
        t_m[d]    = 0;
        lfsr_m[d] = 8'hA5;
      end else if (t_m[d] == 0) begin
        if (start) begin
          pat_m[d] = pattern;
          len_m[d] = (rep == 0) ? 1 : int'(rep) * P + (int'(rep) - 1) * gap_m[d] + 1;
          t_m[d]   = 1;
        end
      end else if (t_m[d] == len_m[d]) begin
        t_m[d] = 0;
      end else begin
        t_m[d]++;
      end

      if (t_m[d] == 0) begin
        exp_m[d] = 4'b0000;
      end else if (t_m[d] == len_m[d]) begin
        exp_m[d] = 4'b0001;
      end else begin
        int o;
        o = (t_m[d] - 1) % (P + gap_m[d]);
        if (o < P) begin
          exp_m[d] = {pat_m[d][P-1-o], 3'b110};
        end else begin
`ifdef SERIAL_PATTERN_GEN_LFSR_FILL_EN
          exp_m[d]  = {lfsr_m[d][7], 3'b010};
          lfsr_m[d] = {lfsr_m[d][6:0], lfsr_m[d][7] ^ lfsr_m[d][5] ^ lfsr_m[d][4] ^ lfsr_m[d][3]};
`else
          exp_m[d] = 4'b0010;
`endif
        end
      end
    end
  endtask

  initial begin
    gap_m[0] = GAP_A;
    gap_m[1] = GAP_B;
    t_m[0] = 0;  t_m[1] = 0;
    len_m[0] = 0; len_m[1] = 0;
    lfsr_m[0] = 8'hA5; lfsr_m[1] = 8'hA5;
    exp_m[0] = '0; exp_m[1] = '0;
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (resetn) begin
        check("a_cycle", {28'd0, bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.done}, {28'd0, exp_m[0]});
        check("b_cycle", {28'd0, bus_b.w, bus_b.w_valid, bus_b.busy, bus_b.done}, {28'd0, exp_m[1]});
      end
    end
  end

  // Capture vectors: newest sample in bit 0, sample 1 ends up highest.
  logic [31:0] aw, av, ab, ad, bw, bv, bb, bd;

  task automatic cap_clear();
    aw = '0; av = '0; ab = '0; ad = '0;
    bw = '0; bv = '0; bb = '0; bd = '0;
  endtask

  task automatic capture(input int n);
    repeat (n) begin
      @(negedge clk);
      aw = {aw[30:0], bus_a.w};  av = {av[30:0], bus_a.w_valid};
      ab = {ab[30:0], bus_a.busy}; ad = {ad[30:0], bus_a.done};
      bw = {bw[30:0], bus_b.w};  bv = {bv[30:0], bus_b.w_valid};
      bb = {bb[30:0], bus_b.busy}; bd = {bd[30:0], bus_b.done};
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Returns just after the accepting edge, start already released.
  task automatic pulse_start(input logic [P-1:0] pat, input logic [C-1:0] r);
    pattern = pat;
    rep     = r;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  int done_seen;

  initial begin
    resetn  = 1'b0;
    start   = 1'b0;
    pattern = '0;
    rep     = '0;
    cap_clear();

    // Reset state
    #12;
    check("reset_outs_a", {28'd0, bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.done}, 32'd0);
    check("reset_outs_b", {28'd0, bus_b.w, bus_b.w_valid, bus_b.busy, bus_b.done}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;

    // Idle with start low
    cap_clear();
    capture(10);
    check("idle_any_a", {31'd0, |{aw[9:0], av[9:0], ab[9:0], ad[9:0]}}, 32'd0);
    check("idle_any_b", {31'd0, |{bw[9:0], bv[9:0], bb[9:0], bd[9:0]}}, 32'd0);
    idle_cycles(1);

    // 111 x2: GAP=2 gives 1,1,1,gap,gap,1,1,1 then done on cycle 9
    pulse_start(3'b111, 4'd2);
    cap_clear();
    capture(10);
`ifdef SERIAL_PATTERN_GEN_LFSR_FILL_EN
    check("p111_a_w", aw[9:0], 32'b1111011100);
`else
    check("p111_a_w", aw[9:0], 32'b1110011100);
`endif
    check("p111_a_valid", av[9:0], 32'b1110011100);
    check("p111_a_busy",  ab[9:0], 32'b1111111100);
    check("p111_a_done",  ad[9:0], 32'b0000000010);
    check("p111_b_w",     bw[9:0], 32'b1111110000);
    check("p111_b_done",  bd[9:0], 32'b0000001000);
    idle_cycles(2);

    // 101 x3: GAP=0 instance streams 9 contiguous bits
    pulse_start(3'b101, 4'd3);
    cap_clear();
    capture(14);
    check("p101_b_w",     bw[13:4], 32'b1011011010);
    check("p101_b_valid", bv[13:4], 32'b1111111110);
    check("p101_b_done",  bd[13:4], 32'b0000000001);
    check("p101_a_valid", av[13:0], 32'b11100111001110);
    check("p101_a_done",  ad[13:0], 32'b00000000000001);
    idle_cycles(2);

    // repeat 0: done one cycle after the start edge, no bits
    pulse_start(3'b111, 4'd0);
    cap_clear();
    capture(3);
    check("r0_a_done",  ad[2:0], 32'b100);
    check("r0_a_valid", av[2:0], 32'b000);
    check("r0_b_done",  bd[2:0], 32'b100);
    check("r0_b_busy",  bb[2:0], 32'b000);
    idle_cycles(2);

    // Start and pattern changed mid-burst are ignored
    pulse_start(3'b110, 4'd1);
    cap_clear();
    capture(1);
    pattern = 3'b001;
    start   = 1'b1;
    capture(1);
    start   = 1'b0;
    capture(3);
    check("ign_a_w",    aw[4:0], 32'b11000);
    check("ign_a_done", ad[4:0], 32'b00010);
    check("ign_b_w",    bw[4:0], 32'b11000);
    check("ign_b_done", bd[4:0], 32'b00010);
    idle_cycles(2);

    // Asynchronous reset during the second bit of 111 x4
    pulse_start(3'b111, 4'd4);
    @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    check("abort_outs_a", {28'd0, bus_a.w, bus_a.w_valid, bus_a.busy, bus_a.done}, 32'd0);
    check("abort_outs_b", {28'd0, bus_b.w, bus_b.w_valid, bus_b.busy, bus_b.done}, 32'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    done_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus_a.done || bus_b.done) done_seen++;
    end
    check("abort_no_done", done_seen, 32'd0);
    idle_cycles(1);

    // Fresh burst after reset behaves as from reset (LFSR back at seed)
    pulse_start(3'b111, 4'd2);
    cap_clear();
    capture(10);
`ifdef SERIAL_PATTERN_GEN_LFSR_FILL_EN
    check("post_rst_a_w", aw[9:0], 32'b1111011100);
`else
    check("post_rst_a_w", aw[9:0], 32'b1110011100);
`endif
    check("post_rst_a_done", ad[9:0], 32'b0000000010);
    check("post_rst_b_w",    bw[9:0], 32'b1111110000);
    idle_cycles(3);

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule
